// File: rtl/mux_pkg.sv
// Shared constants and select type for the 8:1 mux slice.
package mux_pkg;

  localparam int unsigned N_IN  = 8;
  localparam int unsigned SEL_W = 3;

  typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/mux_2x1.sv
// WIDTH-wide 2:1 mux leaf used to build the 8:1 select tree.
module mux_2x1 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] y
);

  // An unknown select yields all-X rather than a partial merge of a and b.
  always_comb begin
    case (s)
      1'b0:    y = a;
      1'b1:    y = b;
      default: y = 'x;
    endcase
  end

endmodule

// File: rtl/mux_8x1.sv
// 8:1 mux: combinational tree output, one-hot select decode, and an enabled output register.
module mux_8x1
  import mux_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_IN*WIDTH-1:0] in,
  input  sel_t                  sel,
  input  logic                  en,
  output logic [WIDTH-1:0]      y,
  output logic [WIDTH-1:0]      y_q,
  output logic                  y_valid,
  output logic [N_IN-1:0]       sel_onehot
);

  logic [WIDTH-1:0] lvl0 [N_IN/2];
  logic [WIDTH-1:0] lvl1 [N_IN/4];
  logic [WIDTH-1:0] y_reg_q;
  logic             valid_q;

  // Level i of the tree is steered by sel[i].
  for (genvar k = 0; k < N_IN / 2; k++) begin : g_l0
    mux_2x1 #(
      .WIDTH(WIDTH)
    ) u_mux (
      .a(in[(2 * k) * WIDTH +: WIDTH]),
      .b(in[(2 * k + 1) * WIDTH +: WIDTH]),
      .s(sel[0]),
      .y(lvl0[k])
    );
  end

  for (genvar k = 0; k < N_IN / 4; k++) begin : g_l1
    mux_2x1 #(
      .WIDTH(WIDTH)
    ) u_mux (
      .a(lvl0[2 * k]),
      .b(lvl0[2 * k + 1]),
      .s(sel[1]),
      .y(lvl1[k])
    );
  end

  mux_2x1 #(
    .WIDTH(WIDTH)
  ) u_l2 (
    .a(lvl1[0]),
    .b(lvl1[1]),
    .s(sel[2]),
    .y(y)
  );

  always_comb begin
    sel_onehot = '0;
    for (int k = 0; k < N_IN; k++) begin
      sel_onehot[k] = (sel == SEL_W'(k));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_reg_q <= '0;
      valid_q <= 1'b0;
    end else if (en) begin
      y_reg_q <= y;
      valid_q <= 1'b1;
    end
  end

  assign y_q     = y_reg_q;
  assign y_valid = valid_q;

endmodule

// File: tb/tb_mux_8x1.sv
// Self-checking bench for mux_8x1 at WIDTH=1 and WIDTH=4 against an arithmetic reference model.
module tb_mux_8x1;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [2:0]  sel;
  logic [7:0]  in1;
  logic [31:0] in4;

  logic       y1, yq1, v1;
  logic [3:0] y4, yq4;
  logic       v4;
  logic [7:0] oh1, oh4;

  int checks = 0;
  int passed = 0;

  logic [3:0] exp_yq1, exp_yq4;
  logic       exp_v1, exp_v4;

  always #5 clk = ~clk;

  mux_8x1 #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in(in1), .sel(sel), .en(en),
    .y(y1), .y_q(yq1), .y_valid(v1), .sel_onehot(oh1)
  );

  mux_8x1 #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in(in4), .sel(sel), .en(en),
    .y(y4), .y_q(yq4), .y_valid(v4), .sel_onehot(oh4)
  );

  function automatic logic [3:0] ref_mux(input logic [31:0] data, input int s, input int w);
    logic [31:0] shifted;
    shifted = data >> (s * w);
    return 4'(shifted % (32'd1 << w));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_comb(input string tag);
    check({tag, ":y1"}, 32'(y1), 32'(ref_mux(32'(in1), int'(sel), 1)));
    check({tag, ":y4"}, 32'(y4), 32'(ref_mux(in4, int'(sel), 4)));
    check({tag, ":oh1"}, 32'(oh1), 32'(8'd1 << sel));
    check({tag, ":oh4"}, 32'(oh4), 32'(8'd1 << sel));
  endtask

  // Advance one clock edge, updating the model from the inputs present at that edge.
  task automatic clock_step(input string tag);
    if (rst) begin
      exp_yq1 = '0; exp_v1 = 1'b0; exp_yq4 = '0; exp_v4 = 1'b0;
    end else if (en) begin
      exp_yq1 = ref_mux(32'(in1), int'(sel), 1); exp_v1 = 1'b1;
      exp_yq4 = ref_mux(in4, int'(sel), 4);      exp_v4 = 1'b1;
    end
    @(posedge clk);
    #1;
    check({tag, ":yq1"}, 32'(yq1), 32'(exp_yq1));
    check({tag, ":v1"}, 32'(v1), 32'(exp_v1));
    check({tag, ":yq4"}, 32'(yq4), 32'(exp_yq4));
    check({tag, ":v4"}, 32'(v4), 32'(exp_v4));
  endtask

  logic [7:0] pat_a, pat_b;

  initial begin
    exp_yq1 = '0; exp_yq4 = '0; exp_v1 = 1'b0; exp_v4 = 1'b0;
    rst = 1'b1; en = 1'b0; sel = 3'd0; in1 = 8'h00; in4 = 32'h0;

    // Reset state.
    clock_step("reset");
    check("reset_yq1_zero", 32'(yq1), 32'd0);
    check("reset_v1_zero", 32'(v1), 32'd0);

    // Alternating pattern, sel walked 0..7 with the register idle.
    rst = 1'b0; en = 1'b0; in1 = 8'b10101010; in4 = 32'hFEDCBA98;
    pat_a = 8'b10101010;
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      #1;
      check_comb("walk_aa");
      check("walk_aa_const", 32'(y1), 32'(pat_a[s]));
      #9;
    end

    in1 = 8'b11001100; in4 = 32'h01234567;
    pat_b = 8'b11001100;
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      #1;
      check_comb("walk_cc");
      check("walk_cc_const", 32'(y1), 32'(pat_b[s]));
      #9;
    end

    // Reset then one enabled capture.
    rst = 1'b1; en = 1'b0;
    clock_step("rst_edge");
    rst = 1'b0; en = 1'b1; in1 = 8'hAA; sel = 3'd3;
    clock_step("capture");
    check("capture_yq1_one", 32'(yq1), 32'd1);
    check("capture_v1_one", 32'(v1), 32'd1);

    // Hold: combinational path moves, register stays.
    en = 1'b0; sel = 3'd4;
    #1;
    check("hold_y1_now_zero", 32'(y1), 32'd0);
    check("hold_yq1_before_edge", 32'(yq1), 32'd1);
    clock_step("hold");
    check("hold_yq1_after_edge", 32'(yq1), 32'd1);

    // Reset wins over enable.
    rst = 1'b1; en = 1'b1;
    #1;
    check("rst_comb_live", 32'(y1), 32'd0);
    clock_step("rst_en");
    check("rst_en_yq1", 32'(yq1), 32'd0);
    check("rst_en_v1", 32'(v1), 32'd0);

    // Wide data path.
    rst = 1'b0; en = 1'b1; in4 = 32'h76543210; sel = 3'd5;
    #1;
    check("w4_y_sel5", 32'(y4), 32'h5);
    clock_step("w4_capture");
    check("w4_yq_sel5", 32'(yq4), 32'h5);

    // Random traffic.
    for (int i = 0; i < 60; i++) begin
      rst = ($urandom_range(0, 7) == 0);
      en  = 1'($urandom_range(0, 1));
      sel = 3'($urandom_range(0, 7));
      in1 = 8'($urandom);
      in4 = $urandom;
      #1;
      check_comb("rand");
      clock_step("rand");
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
